icache_axi_refill_mo: RTL and testbench



---
 rtl/icache_refill_pkg.sv | 20 ++
 rtl/icache_refill_slot.sv | 77 +++++++
 rtl/icache_axi_refill_mo.sv | 147 ++++++++++++++
 tb/tb_icache_axi_refill_mo.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared types and helpers for the I$ AXI refill adapter
package icache_refill_pkg;
  localparam int unsigned DefLineWidth  = 128;
  localparam int unsigned DefPAddrWidth = 56;
  localparam int unsigned DefTidWidth   = 2;
  typedef enum logic [1:0] {S_FREE, S_AR_PEND, S_FILL, S_DONE} slot_state_e;
  typedef struct packed {
    logic [DefPAddrWidth-1:0] paddr;
    logic                     nc;
    logic [DefTidWidth-1:0]   tid;
  } refill_req_t;
  typedef struct packed {
    logic [DefLineWidth-1:0] data;
    logic [DefTidWidth-1:0]  tid;
    logic                    err;
  } refill_rtrn_t;
  function automatic int unsigned beats(input int unsigned line_w, input int unsigned data_w);
    return line_w / data_w;
  endfunction
endpackage

// File: rtl/icache_refill_slot.sv
// icache_refill_slot: one outstanding refill - FSM, beat counter, line buffer, err/kill flags
module icache_refill_slot
  import icache_refill_pkg::*;
#(
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned TidWidth     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    alloc_i,
  input  logic                    nc_i,
  input  logic [TidWidth-1:0]     tid_i,
  input  logic                    ar_hs_i,
  input  logic                    beat_i,
  input  logic [AxiDataWidth-1:0] data_i,
  input  logic                    last_i,
  input  logic                    err_i,
  input  logic                    rtrn_hs_i,
  output slot_state_e             state_o,
  output logic [LineWidth-1:0]    data_o,
  output logic [TidWidth-1:0]     tid_o,
  output logic                    err_o
);
  localparam int unsigned Beats = beats(LineWidth, AxiDataWidth);
  localparam int unsigned CntW  = Beats > 1 ? $clog2(Beats) : 1;
  slot_state_e                        r_state;
  logic                               r_killed, r_nc, r_err;
  logic [TidWidth-1:0]                r_tid;
  logic [CntW-1:0]                    r_cnt;
  logic [Beats-1:0][AxiDataWidth-1:0] r_buf;
  logic [CntW-1:0]                    w_idx;
  assign w_idx   = r_nc ? '0 : r_cnt;
  assign state_o = r_state;
  assign data_o  = r_buf;
  assign tid_o   = r_tid;
  assign err_o   = r_err;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_FREE;
      r_killed <= 1'b0;
      r_nc     <= 1'b0;
      r_err    <= 1'b0;
      r_tid    <= '0;
      r_cnt    <= '0;
      r_buf    <= '0;
    end else begin
      case (r_state)
        S_FREE: if (alloc_i) begin
          r_state  <= S_AR_PEND;
          r_killed <= 1'b0;
          r_err    <= 1'b0;
          r_cnt    <= '0;
          r_nc     <= nc_i;
          r_tid    <= tid_i;
        end
        S_AR_PEND: begin
          if (flush_i) r_killed <= 1'b1;
          if (ar_hs_i) r_state <= S_FILL;
        end
        S_FILL: begin
          if (flush_i) r_killed <= 1'b1;
          if (beat_i) begin
            r_buf[w_idx] <= data_i;
            r_cnt        <= r_cnt + 1'b1;
            r_err        <= r_err | err_i;
            if (last_i) r_state <= (r_killed || flush_i) ? S_FREE : S_DONE;
          end
        end
        default: if (flush_i || rtrn_hs_i) r_state <= S_FREE;
      endcase
    end
  end
  // Routed beats must only ever hit a slot that is waiting for data.
  assert property (@(posedge clk_i) disable iff (!rst_ni) beat_i |-> r_state == S_FILL);
endmodule

// File: rtl/icache_axi_refill_mo.sv
// icache_axi_refill_mo: I$ miss/bypass to AXI AR/R refill adapter with NumSlots outstanding lines.
// Optional perf counters (perf_refills_o, perf_lat_max_o) under macro ICACHE_REFILL_PERF_EN.
module icache_axi_refill_mo
  import icache_refill_pkg::*;
#(
  parameter int unsigned LineWidth    = 128,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned PAddrWidth   = 56,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiIdBase    = 0,
  parameter int unsigned NumSlots     = 2,
  parameter int unsigned TidWidth     = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [PAddrWidth-1:0]   req_paddr_i,
  input  logic                    req_nc_i,
  input  logic [TidWidth-1:0]     req_tid_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [PAddrWidth-1:0]   ar_addr_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [AxiIdWidth-1:0]   ar_id_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [AxiDataWidth-1:0] r_data_i,
  input  logic [AxiIdWidth-1:0]   r_id_i,
  input  logic                    r_last_i,
  input  logic [1:0]              r_resp_i,
  output logic                    rtrn_valid_o,
  input  logic                    rtrn_ready_i,
  output logic [LineWidth-1:0]    rtrn_data_o,
  output logic [TidWidth-1:0]     rtrn_tid_o,
  output logic                    rtrn_err_o,
  output logic                    busy_o
`ifdef ICACHE_REFILL_PERF_EN
  ,
  output logic [31:0]             perf_refills_o,
  output logic [15:0]             perf_lat_max_o
`endif
);
  localparam int unsigned Beats = beats(LineWidth, AxiDataWidth);
  localparam int unsigned SlotW = NumSlots > 1 ? $clog2(NumSlots) : 1;
  localparam logic [PAddrWidth-1:0] LineMask = PAddrWidth'(LineWidth / 8 - 1);
  localparam logic [PAddrWidth-1:0] BeatMask = PAddrWidth'(AxiDataWidth / 8 - 1);
  slot_state_e               w_state [NumSlots];
  logic [LineWidth-1:0]      w_data [NumSlots];
  logic [TidWidth-1:0]       w_tid [NumSlots];
  logic [NumSlots-1:0]       w_err, w_free, w_done, w_alloc, w_ar_hs, w_beat, w_rtrn_hs;
  logic [SlotW-1:0]          w_free_idx, w_done_idx, w_rsel, r_ar_slot, r_hold_slot;
  logic [AxiIdWidth-1:0]     w_rslot;
  logic                      w_accept, w_ar_fire, w_rerr, r_ar_valid, r_hold;
  logic [PAddrWidth-1:0]     r_ar_addr;
  logic [7:0]                r_ar_len;
  refill_req_t               w_req;
  refill_rtrn_t              w_rtrn;
  assign w_req       = '{paddr: req_paddr_i, nc: req_nc_i, tid: req_tid_i};
  assign req_ready_o = (|w_free) && (!r_ar_valid || ar_ready_i);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_ar_fire   = r_ar_valid && ar_ready_i;
  assign w_rslot     = r_id_i - AxiIdWidth'(AxiIdBase);
  assign w_rerr      = r_resp_i inside {2'b10, 2'b11};
  assign w_rsel      = r_hold ? r_hold_slot : w_done_idx;
  assign w_rtrn      = '{data: w_data[w_rsel], tid: w_tid[w_rsel], err: w_err[w_rsel]};
  assign ar_valid_o   = r_ar_valid;
  assign ar_addr_o    = r_ar_addr;
  assign ar_len_o     = r_ar_len;
  assign ar_size_o    = 3'($clog2(AxiDataWidth / 8));
  assign ar_id_o      = AxiIdWidth'(AxiIdBase) + AxiIdWidth'(r_ar_slot);
  assign r_ready_o    = 1'b1;
  assign rtrn_valid_o = |w_done;
  assign rtrn_data_o  = w_rtrn.data;
  assign rtrn_tid_o   = w_rtrn.tid;
  assign rtrn_err_o   = w_rtrn.err;
  assign busy_o       = ~&w_free;
  always_comb begin
    w_free_idx = '0;
    w_done_idx = '0;
    for (int i = int'(NumSlots) - 1; i >= 0; i--) begin
      if (w_free[i]) w_free_idx = SlotW'(i);
      if (w_done[i]) w_done_idx = SlotW'(i);
    end
  end
  for (genvar s = 0; s < NumSlots; s++) begin : g_slot
    assign w_free[s]    = w_state[s] == S_FREE;
    assign w_done[s]    = w_state[s] == S_DONE;
    assign w_alloc[s]   = w_accept && w_free_idx == SlotW'(s);
    assign w_ar_hs[s]   = w_ar_fire && r_ar_slot == SlotW'(s);
    assign w_beat[s]    = r_valid_i && w_rslot == AxiIdWidth'(s);
    assign w_rtrn_hs[s] = rtrn_valid_o && rtrn_ready_i && w_rsel == SlotW'(s);
    icache_refill_slot #(
      .LineWidth(LineWidth), .AxiDataWidth(AxiDataWidth), .TidWidth(TidWidth)
    ) u_slot (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .alloc_i(w_alloc[s]), .nc_i(w_req.nc), .tid_i(w_req.tid),
      .ar_hs_i(w_ar_hs[s]), .beat_i(w_beat[s]), .data_i(r_data_i),
      .last_i(r_last_i), .err_i(w_rerr), .rtrn_hs_i(w_rtrn_hs[s]),
      .state_o(w_state[s]), .data_o(w_data[s]), .tid_o(w_tid[s]), .err_o(w_err[s])
    );
  end
  // A presented line stays locked until handshake or flush so data never switches under valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ar_valid  <= 1'b0;
      r_ar_addr   <= '0;
      r_ar_len    <= '0;
      r_ar_slot   <= '0;
      r_hold      <= 1'b0;
      r_hold_slot <= '0;
    end else begin
      if (w_accept) begin
        r_ar_valid <= 1'b1;
        r_ar_addr  <= w_req.nc ? (w_req.paddr & ~BeatMask) : (w_req.paddr & ~LineMask);
        r_ar_len   <= w_req.nc ? 8'd0 : 8'(Beats - 1);
        r_ar_slot  <= w_free_idx;
      end else if (w_ar_fire) begin
        r_ar_valid <= 1'b0;
      end
      r_hold      <= rtrn_valid_o && !rtrn_ready_i && !flush_i;
      r_hold_slot <= w_rsel;
    end
  end
  assert property (@(posedge clk_i) disable iff (!rst_ni) r_valid_i |-> 32'(w_rslot) < NumSlots);
`ifdef ICACHE_REFILL_PERF_EN
  logic [15:0] r_lat [NumSlots];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lat          <= '{default: '0};
      perf_refills_o <= '0;
      perf_lat_max_o <= '0;
    end else begin
      for (int i = 0; i < int'(NumSlots); i++)
        r_lat[i] <= w_alloc[i] ? 16'd1 :
                    (!w_free[i] && !(rtrn_valid_o && w_rsel == SlotW'(i)) && r_lat[i] != 16'hFFFF) ?
                    r_lat[i] + 16'd1 : r_lat[i];
      if (|w_rtrn_hs) begin
        perf_refills_o <= perf_refills_o + 32'd1;
        if (r_lat[w_rsel] > perf_lat_max_o) perf_lat_max_o <= r_lat[w_rsel];
      end
    end
  end
`endif
endmodule

// File: tb/tb_icache_axi_refill_mo.sv
// tb_icache_axi_refill_mo: table-driven single refills plus hand-written multi-slot, flush and reset sequences
module tb_icache_axi_refill_mo;
  logic         clk_i, rst_ni, flush_i;
  logic         req_valid_i, req_ready_o, req_nc_i;
  logic [55:0]  req_paddr_i, ar_addr_o;
  logic [1:0]   req_tid_i, rtrn_tid_o, r_resp_i;
  logic         ar_valid_o, ar_ready_i;
  logic [7:0]   ar_len_o;
  logic [2:0]   ar_size_o;
  logic [3:0]   ar_id_o, r_id_i;
  logic         r_valid_i, r_ready_o, r_last_i;
  logic [63:0]  r_data_i;
  logic         rtrn_valid_o, rtrn_ready_i, rtrn_err_o, busy_o;
  logic [127:0] rtrn_data_o;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic [55:0]  paddr;
    logic         nc;
    logic [1:0]   tid;
    logic [63:0]  d0, d1;
    logic [1:0]   r0, r1;
    logic [55:0]  addr;
    logic [7:0]   len;
    logic [127:0] data;
    logic         err;
  } vec_t;
  vec_t vt [5];

  icache_axi_refill_mo dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_paddr_i(req_paddr_i),
    .req_nc_i(req_nc_i), .req_tid_i(req_tid_i),
    .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
    .ar_len_o(ar_len_o), .ar_size_o(ar_size_o), .ar_id_o(ar_id_o),
    .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_id_i(r_id_i),
    .r_last_i(r_last_i), .r_resp_i(r_resp_i),
    .rtrn_valid_o(rtrn_valid_o), .rtrn_ready_i(rtrn_ready_i), .rtrn_data_o(rtrn_data_o),
    .rtrn_tid_o(rtrn_tid_o), .rtrn_err_o(rtrn_err_o), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  task automatic req(input logic [55:0] a, input logic nc, input logic [1:0] t);
    req_valid_i = 1'b1;
    req_paddr_i = a;
    req_nc_i    = nc;
    req_tid_i   = t;
  endtask

  task automatic beat(input logic [3:0] id, input logic [63:0] d, input logic last, input logic [1:0] resp);
    r_valid_i = 1'b1;
    r_id_i    = id;
    r_data_i  = d;
    r_last_i  = last;
    r_resp_i  = resp;
  endtask

  task automatic chk_reset_vals(input string n);
    chk({n, "_ar_valid"}, ar_valid_o, 0);
    chk({n, "_rtrn_valid"}, rtrn_valid_o, 0);
    chk({n, "_busy"}, busy_o, 0);
    chk({n, "_req_ready"}, req_ready_o, 1);
    chk({n, "_r_ready"}, r_ready_o, 1);
    chk({n, "_rtrn_data"}, rtrn_data_o, 0);
  endtask

  initial begin
    vt[0] = '{56'h8000_1234, 1'b0, 2'd1, 64'hD0, 64'hD1, 2'b00, 2'b00, 56'h8000_1230, 8'd1, {64'hD1, 64'hD0}, 1'b0};
    vt[1] = '{56'h1008, 1'b1, 2'd2, 64'hAB, 64'h0, 2'b00, 2'b00, 56'h1008, 8'd0, {64'h0, 64'hAB}, 1'b0};
    vt[2] = '{56'h12_3456_789A_BCDF, 1'b0, 2'd3, 64'hCAFE_F00D_0000_0001, 64'hDEAD_BEEF_0000_0002,
              2'b10, 2'b00, 56'h12_3456_789A_BCD0, 8'd1, {64'hDEAD_BEEF_0000_0002, 64'hCAFE_F00D_0000_0001}, 1'b1};
    vt[3] = '{56'h2004, 1'b1, 2'd0, 64'h5555, 64'h0, 2'b11, 2'b00, 56'h2000, 8'd0, {64'h0, 64'h5555}, 1'b1};
    vt[4] = '{56'h40, 1'b0, 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 2'b01, 56'h40, 8'd1,
              {64'h1, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0};
    rst_ni = 1'b0; flush_i = 1'b0; req_valid_i = 1'b0; req_paddr_i = '0; req_nc_i = 1'b0; req_tid_i = '0;
    ar_ready_i = 1'b1; r_valid_i = 1'b0; r_data_i = '0; r_id_i = '0; r_last_i = 1'b0; r_resp_i = '0;
    rtrn_ready_i = 1'b0;
    tick(); tick();
    chk_reset_vals("rst");
    rst_ni = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      req(vt[v].paddr, vt[v].nc, vt[v].tid);
      @(negedge clk_i); chk($sformatf("v%0d_req_ready", v), req_ready_o, 1);
      tick();
      req_valid_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("v%0d_ar_valid", v), ar_valid_o, 1);
      chk($sformatf("v%0d_ar_addr", v), ar_addr_o, vt[v].addr);
      chk($sformatf("v%0d_ar_len", v), ar_len_o, vt[v].len);
      chk($sformatf("v%0d_ar_size", v), ar_size_o, 3);
      chk($sformatf("v%0d_ar_id", v), ar_id_o, 0);
      tick();
      beat(4'd0, vt[v].d0, vt[v].nc, vt[v].r0);
      @(negedge clk_i);
      chk($sformatf("v%0d_ar_drop", v), ar_valid_o, 0);
      chk($sformatf("v%0d_rtrn_early0", v), rtrn_valid_o, 0);
      tick();
      if (!vt[v].nc) begin
        beat(4'd0, vt[v].d1, 1'b1, vt[v].r1);
        @(negedge clk_i); chk($sformatf("v%0d_rtrn_early1", v), rtrn_valid_o, 0);
        tick();
      end
      r_valid_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("v%0d_rtrn_valid", v), rtrn_valid_o, 1);
      chk($sformatf("v%0d_rtrn_tid", v), rtrn_tid_o, vt[v].tid);
      chk($sformatf("v%0d_rtrn_err", v), rtrn_err_o, vt[v].err);
      chk($sformatf("v%0d_rtrn_data", v), vt[v].nc ? {64'h0, rtrn_data_o[63:0]} : rtrn_data_o, vt[v].data);
      rtrn_ready_i = 1'b1;
      tick();
      rtrn_ready_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("v%0d_rtrn_gone", v), rtrn_valid_o, 0);
      chk($sformatf("v%0d_busy", v), busy_o, 0);
      tick();
    end

    // Two outstanding refills with AR back-pressure, out-of-order R, full-slot stall
    ar_ready_i = 1'b0;
    req(56'h100, 1'b0, 2'd1);
    @(negedge clk_i); chk("mo_req_ready_a", req_ready_o, 1);
    tick();
    req(56'h200, 1'b0, 2'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      chk($sformatf("mo_ar_valid_%0d", k), ar_valid_o, 1);
      chk($sformatf("mo_ar_addr_%0d", k), ar_addr_o, 56'h100);
      chk($sformatf("mo_ar_id_%0d", k), ar_id_o, 0);
      chk($sformatf("mo_req_stall_%0d", k), req_ready_o, 0);
      tick();
    end
    ar_ready_i = 1'b1;
    @(negedge clk_i); chk("mo_req_ready_b", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("mo_ar2_valid", ar_valid_o, 1);
    chk("mo_ar2_addr", ar_addr_o, 56'h200);
    chk("mo_ar2_id", ar_id_o, 1);
    tick();
    req(56'h300, 1'b1, 2'd3);
    beat(4'd1, 64'hB0, 1'b0, 2'b00);
    @(negedge clk_i); chk("full_ready0", req_ready_o, 0); chk("full_busy", busy_o, 1);
    tick();
    beat(4'd1, 64'hB1, 1'b1, 2'b00);
    @(negedge clk_i); chk("full_ready1", req_ready_o, 0);
    tick();
    beat(4'd0, 64'hA0, 1'b0, 2'b00);
    @(negedge clk_i); chk("ooo_valid", rtrn_valid_o, 1); chk("ooo_tid", rtrn_tid_o, 2);
    tick();
    beat(4'd0, 64'hA1, 1'b1, 2'b00);
    tick();
    r_valid_i = 1'b0;
    rtrn_ready_i = 1'b1;
    @(negedge clk_i);
    chk("hold_tid", rtrn_tid_o, 2);
    chk("hold_data", rtrn_data_o, {64'hB1, 64'hB0});
    chk("full_ready_hs", req_ready_o, 0);
    tick();
    rtrn_ready_i = 1'b0;
    @(negedge clk_i);
    chk("second_valid", rtrn_valid_o, 1);
    chk("second_tid", rtrn_tid_o, 1);
    chk("second_data", rtrn_data_o, {64'hA1, 64'hA0});
    chk("freed_ready", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    rtrn_ready_i = 1'b1;
    @(negedge clk_i);
    chk("ar3_addr", ar_addr_o, 56'h300);
    chk("ar3_len", ar_len_o, 0);
    chk("ar3_id", ar_id_o, 1);
    tick();
    rtrn_ready_i = 1'b0;
    beat(4'd1, 64'hC0, 1'b1, 2'b00);
    @(negedge clk_i); chk("third_pre", rtrn_valid_o, 0);
    tick();
    r_valid_i = 1'b0;
    rtrn_ready_i = 1'b1;
    @(negedge clk_i);
    chk("third_tid", rtrn_tid_o, 3);
    chk("third_data", {64'h0, rtrn_data_o[63:0]}, {64'h0, 64'hC0});
    tick();
    rtrn_ready_i = 1'b0;
    @(negedge clk_i); chk("mo_idle", busy_o, 0);
    tick();

    // Flush during FILL: beats drained, no return
    req(56'h500, 1'b0, 2'd1);
    tick();
    req_valid_i = 1'b0;
    tick();
    beat(4'd0, 64'h50, 1'b0, 2'b00);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    beat(4'd0, 64'h51, 1'b1, 2'b00);
    @(negedge clk_i); chk("kill_busy", busy_o, 1);
    tick();
    r_valid_i = 1'b0;
    @(negedge clk_i); chk("kill_no_rtrn", rtrn_valid_o, 0); chk("kill_idle", busy_o, 0);
    tick();

    // Flush while DONE, with a new request in the same cycle
    req(56'h700, 1'b0, 2'd3);
    tick();
    req_valid_i = 1'b0;
    tick();
    beat(4'd0, 64'hE0, 1'b0, 2'b00);
    tick();
    beat(4'd0, 64'hE1, 1'b1, 2'b00);
    tick();
    r_valid_i = 1'b0;
    flush_i = 1'b1;
    req(56'h600, 1'b1, 2'd2);
    @(negedge clk_i);
    chk("fd_valid", rtrn_valid_o, 1);
    chk("fd_tid", rtrn_tid_o, 3);
    chk("fd_req_ready", req_ready_o, 1);
    tick();
    flush_i = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("fd_dropped", rtrn_valid_o, 0);
    chk("fd_ar_id", ar_id_o, 1);
    chk("fd_ar_addr", ar_addr_o, 56'h600);
    tick();
    beat(4'd1, 64'h66, 1'b1, 2'b00);
    tick();
    r_valid_i = 1'b0;
    rtrn_ready_i = 1'b1;
    @(negedge clk_i);
    chk("fd_new_valid", rtrn_valid_o, 1);
    chk("fd_new_tid", rtrn_tid_o, 2);
    chk("fd_new_data", {64'h0, rtrn_data_o[63:0]}, {64'h0, 64'h66});
    tick();
    rtrn_ready_i = 1'b0;
    @(negedge clk_i); chk("fd_idle", busy_o, 0);
    tick();

    // Asynchronous reset mid-burst
    req(56'h900, 1'b0, 2'd1);
    tick();
    req_valid_i = 1'b0;
    tick();
    beat(4'd0, 64'h99, 1'b0, 2'b00);
    tick();
    r_valid_i = 1'b0;
    @(negedge clk_i); chk("mid_busy", busy_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst_ni = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
